// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Two-master to one-slave memory port arbiter. Round-robin
//             selection with lock-until-grant, in-order response routing
//             through a small owner-ID FIFO, and zero added latency on both
//             the request and the response paths.
//  Ports    : clk, rst                      clock, async active-high reset
//             m0_* / m1_*                   master request/response ports
//             s_*                           shared slave request/response
//             protocol_err_o                sticky: response with nothing owed
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (instruction side)
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_be_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,
    // master 1 (data side)
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_be_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,
    // shared slave
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_be_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic        s_err_i,
    input  logic [31:0] s_rdata_i,
    output logic        protocol_err_o
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

    logic               r_prio;
    logic               r_lock_valid;
    logic               r_lock_id;
    logic               r_protocol_err;
    logic               r_owner [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_sel_id;
    logic w_sel_valid;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_owner[r_rd_ptr];

    // A locked master keeps the port only while it is still requesting; the
    // lock never overrides a master that has gone away.
    always_comb begin
        w_sel_id = 1'b0;
        if (r_lock_valid && (r_lock_id ? m1_req_i : m0_req_i)) begin
            w_sel_id = r_lock_id;
        end else if (m0_req_i && m1_req_i) begin
            w_sel_id = r_prio;
        end else begin
            w_sel_id = m1_req_i;
        end
    end

    // With the owner FIFO full nothing is offered to the slave, so a pop in
    // the same cycle cannot let a grant slip through.
    assign w_sel_valid = !w_full && (m0_req_i || m1_req_i);
    assign w_push      = w_sel_valid && s_gnt_i;
    assign w_pop       = s_rvalid_i && !w_empty;

    // request path: pure mux, no registers
    assign s_req_o   = w_sel_valid;
    assign s_we_o    = w_sel_id ? m1_we_i    : m0_we_i;
    assign s_addr_o  = w_sel_id ? m1_addr_i  : m0_addr_i;
    assign s_wdata_o = w_sel_id ? m1_wdata_i : m0_wdata_i;
    assign s_be_o    = w_sel_id ? m1_be_i    : m0_be_i;

    assign m0_gnt_o = w_push && !w_sel_id;
    assign m1_gnt_o = w_push &&  w_sel_id;

    // response path: routed by the oldest outstanding owner
    assign m0_rvalid_o = w_pop && !w_head;
    assign m1_rvalid_o = w_pop &&  w_head;
    assign m0_err_o    = m0_rvalid_o && s_err_i;
    assign m1_err_o    = m1_rvalid_o && s_err_i;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    assign protocol_err_o = r_protocol_err;

    // arbitration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio         <= 1'b0;
            r_lock_valid   <= 1'b0;
            r_lock_id      <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_prio <= ~w_sel_id;
            end
            // Lock is re-evaluated whenever a request is on the bus: set
            // while the slave stalls, released on the grant.
            if (w_sel_valid) begin
                r_lock_valid <= !s_gnt_i;
                r_lock_id    <= w_sel_id;
            end
            if (s_rvalid_i && w_empty) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // owner FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_owner[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_owner[r_wr_ptr] <= w_sel_id;
                r_wr_ptr          <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. Expected response
//             owners are queued when a grant is expected and popped when the
//             bench drives a slave response.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_gnt, s_rvalid, s_err;
    logic [31:0] s_rdata;
    logic        protocol_err_o;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_be_i(m0_be), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_be_i(m1_be), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_be_o(s_be_o), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_err_i(s_err),
        .s_rdata_i(s_rdata), .protocol_err_o(protocol_err_o)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h80; m0_wdata = 32'h0; m0_be = 4'h1;
        m1_req = 1'b0; m1_we = 1'b1; m1_addr = 32'h1000; m1_wdata = 32'hA5A50001; m1_be = 4'hF;
        s_gnt = 1'b0; s_rvalid = 1'b1; s_err = 1'b0; s_rdata = 32'hDEADBEEF;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++; if (s_req_o !== 1'b1 || s_addr_o !== 32'h80) begin bad++;
            $display("FAIL reset_mirror got req=%b addr=%h exp req=1 addr=00000080", s_req_o, s_addr_o); end
        total++; if ({m1_rvalid_o, m0_rvalid_o} !== 2'b00) begin bad++;
            $display("FAIL reset_rvalid got=%b exp=00", {m1_rvalid_o, m0_rvalid_o}); end
        total++; if (protocol_err_o !== 1'b0) begin bad++;
            $display("FAIL reset_perr got=%b exp=0", protocol_err_o); end
        m0_req = 1'b0; s_rvalid = 1'b0;
        #1;
        total++; if (s_req_o !== 1'b0) begin bad++;
            $display("FAIL reset_idle_req got=%b exp=0", s_req_o); end
        next_cycle();
        rst = 1'b0;
    endtask

    // Both masters request continuously; responses stream back one cycle
    // after each grant, keeping the FIFO at one entry.
    task automatic test_round_robin();
        bit e, exp_id;
        m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1; s_rvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_id = i[0];
            total++; if (s_addr_o !== (exp_id ? 32'h1000 : 32'h80)) begin bad++;
                $display("FAIL rr_addr cyc=%0d got=%h exp_master=%0d", i, s_addr_o, exp_id); end
            total++; if ({m1_gnt_o, m0_gnt_o} !== (exp_id ? 2'b10 : 2'b01)) begin bad++;
                $display("FAIL rr_gnt cyc=%0d got=%b exp_master=%0d", i, {m1_gnt_o, m0_gnt_o}, exp_id); end
            total++; if (s_we_o !== exp_id || s_be_o !== (exp_id ? 4'hF : 4'h1)) begin bad++;
                $display("FAIL rr_we_be cyc=%0d got we=%b be=%h exp_master=%0d", i, s_we_o, s_be_o, exp_id); end
            if (s_rvalid) begin
                e = exp_q.pop_front();
                total++; if ({m1_rvalid_o, m0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin bad++;
                    $display("FAIL rr_route cyc=%0d got=%b exp_master=%0d", i, {m1_rvalid_o, m0_rvalid_o}, e); end
            end
            exp_q.push_back(exp_id);
            next_cycle();
            s_rvalid = 1'b1; s_rdata = $urandom;
        end
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++; if ({m1_rvalid_o, m0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin bad++;
                $display("FAIL rr_drain got=%b exp_master=%0d", {m1_rvalid_o, m0_rvalid_o}, e); end
            total++; if (m0_rdata_o !== s_rdata || m1_rdata_o !== s_rdata) begin bad++;
                $display("FAIL rr_rdata got=%h/%h exp=%h", m0_rdata_o, m1_rdata_o, s_rdata); end
            next_cycle();
        end
        s_rvalid = 1'b0;
    endtask

    // prio ends up at 1 after granting m0; m0 then stalls and must keep the
    // port while m1 (which has priority) waits.
    task automatic test_lock();
        bit e;
        m0_req = 1'b1; s_gnt = 1'b1;
        @(negedge clk);
        total++; if (m0_gnt_o !== 1'b1) begin bad++;
            $display("FAIL lock_pre_gnt got=%b exp=1", m0_gnt_o); end
        exp_q.push_back(1'b0);
        next_cycle();
        s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h11112222;
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if ({m1_rvalid_o, m0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin bad++;
            $display("FAIL lock_pre_route got=%b exp_master=%0d", {m1_rvalid_o, m0_rvalid_o}, e); end
        next_cycle();
        s_rvalid = 1'b0; m1_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (s_addr_o !== 32'h80 || {m1_gnt_o, m0_gnt_o} !== 2'b00) begin bad++;
                $display("FAIL lock_hold cyc=%0d got addr=%h gnt=%b exp addr=00000080 gnt=00", i, s_addr_o, {m1_gnt_o, m0_gnt_o}); end
            next_cycle();
        end
        s_gnt = 1'b1;
        @(negedge clk);
        total++; if (s_addr_o !== 32'h80 || {m1_gnt_o, m0_gnt_o} !== 2'b01) begin bad++;
            $display("FAIL lock_release got addr=%h gnt=%b exp addr=00000080 gnt=01", s_addr_o, {m1_gnt_o, m0_gnt_o}); end
        exp_q.push_back(1'b0);
        next_cycle();
        m0_req = 1'b0;
        @(negedge clk);
        total++; if (s_addr_o !== 32'h1000 || {m1_gnt_o, m0_gnt_o} !== 2'b10) begin bad++;
            $display("FAIL lock_next got addr=%h gnt=%b exp addr=00001000 gnt=10", s_addr_o, {m1_gnt_o, m0_gnt_o}); end
        exp_q.push_back(1'b1);
        next_cycle();
        m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++; if ({m1_rvalid_o, m0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin bad++;
                $display("FAIL lock_drain got=%b exp_master=%0d", {m1_rvalid_o, m0_rvalid_o}, e); end
            next_cycle();
        end
        s_rvalid = 1'b0;
    endtask

    task automatic test_full();
        bit e;
        m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if ({m1_gnt_o, m0_gnt_o} !== (i[0] ? 2'b10 : 2'b01)) begin bad++;
                $display("FAIL full_fill cyc=%0d got=%b exp_master=%0d", i, {m1_gnt_o, m0_gnt_o}, i[0]); end
            exp_q.push_back(i[0]);
            next_cycle();
        end
        @(negedge clk);
        total++; if (s_req_o !== 1'b0 || {m1_gnt_o, m0_gnt_o} !== 2'b00) begin bad++;
            $display("FAIL full_block got req=%b gnt=%b exp req=0 gnt=00", s_req_o, {m1_gnt_o, m0_gnt_o}); end
        next_cycle();
        s_rvalid = 1'b1; s_rdata = 32'h00000513; s_err = 1'b1;
        @(negedge clk);
        total++; if (s_req_o !== 1'b0 || {m1_gnt_o, m0_gnt_o} !== 2'b00) begin bad++;
            $display("FAIL full_pop_block got req=%b gnt=%b exp req=0 gnt=00", s_req_o, {m1_gnt_o, m0_gnt_o}); end
        e = exp_q.pop_front();
        total++; if ({m1_rvalid_o, m0_rvalid_o} !== (e ? 2'b10 : 2'b01) || m0_rdata_o !== 32'h00000513) begin bad++;
            $display("FAIL full_resp got rv=%b rdata=%h exp_master=%0d rdata=00000513", {m1_rvalid_o, m0_rvalid_o}, m0_rdata_o, e); end
        total++; if ({m1_err_o, m0_err_o} !== (e ? 2'b10 : 2'b01)) begin bad++;
            $display("FAIL full_err got=%b exp_master=%0d", {m1_err_o, m0_err_o}, e); end
        next_cycle();
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_err = 1'b0; s_rdata = 32'h12345678;
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if ({m1_rvalid_o, m0_rvalid_o} !== (e ? 2'b10 : 2'b01) || {m1_err_o, m0_err_o} !== 2'b00) begin bad++;
            $display("FAIL full_second got rv=%b err=%b exp_master=%0d err=00", {m1_rvalid_o, m0_rvalid_o}, {m1_err_o, m0_err_o}, e); end
        next_cycle();
        s_rvalid = 1'b0;
    endtask

    task automatic test_push_pop();
        bit e;
        m1_req = 1'b1; s_gnt = 1'b1;
        @(negedge clk);
        total++; if ({m1_gnt_o, m0_gnt_o} !== 2'b10) begin bad++;
            $display("FAIL pp_first got=%b exp=10", {m1_gnt_o, m0_gnt_o}); end
        exp_q.push_back(1'b1);
        next_cycle();
        m1_req = 1'b0; m0_req = 1'b1; s_rvalid = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if ({m1_gnt_o, m0_gnt_o} !== 2'b01 || {m1_rvalid_o, m0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin bad++;
            $display("FAIL pp_same got gnt=%b rv=%b exp gnt=01 rv_master=%0d", {m1_gnt_o, m0_gnt_o}, {m1_rvalid_o, m0_rvalid_o}, e); end
        exp_q.push_back(1'b0);
        next_cycle();
        m0_req = 1'b0; s_gnt = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if ({m1_rvalid_o, m0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin bad++;
            $display("FAIL pp_after got=%b exp_master=%0d", {m1_rvalid_o, m0_rvalid_o}, e); end
        next_cycle();
        s_rvalid = 1'b0;
    endtask

    task automatic test_stray();
        @(negedge clk);
        total++; if (protocol_err_o !== 1'b0) begin bad++;
            $display("FAIL stray_pre got=%b exp=0", protocol_err_o); end
        next_cycle();
        s_rvalid = 1'b1;
        @(negedge clk);
        total++; if ({m1_rvalid_o, m0_rvalid_o} !== 2'b00) begin bad++;
            $display("FAIL stray_drop got=%b exp=00", {m1_rvalid_o, m0_rvalid_o}); end
        next_cycle();
        s_rvalid = 1'b0;
        repeat (3) next_cycle();
        total++; if (protocol_err_o !== 1'b1) begin bad++;
            $display("FAIL stray_sticky got=%b exp=1", protocol_err_o); end
    endtask

    task automatic test_reset_mid();
        bit e;
        // last grant went to m0, so m1 wins first here
        m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if ({m1_gnt_o, m0_gnt_o} !== (i[0] ? 2'b01 : 2'b10)) begin bad++;
                $display("FAIL rm_fill cyc=%0d got=%b", i, {m1_gnt_o, m0_gnt_o}); end
            next_cycle();
        end
        s_gnt = 1'b0; s_rvalid = 1'b1; rst = 1'b1;
        #1;
        total++; if (protocol_err_o !== 1'b0 || s_req_o !== 1'b1 || s_addr_o !== 32'h80) begin bad++;
            $display("FAIL rm_in_reset got perr=%b req=%b addr=%h exp perr=0 req=1 addr=00000080", protocol_err_o, s_req_o, s_addr_o); end
        total++; if ({m1_rvalid_o, m0_rvalid_o} !== 2'b00) begin bad++;
            $display("FAIL rm_rv_reset got=%b exp=00", {m1_rvalid_o, m0_rvalid_o}); end
        next_cycle();
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        total++; if ({m1_rvalid_o, m0_rvalid_o} !== 2'b00) begin bad++;
            $display("FAIL rm_late_drop got=%b exp=00", {m1_rvalid_o, m0_rvalid_o}); end
        next_cycle();
        s_rvalid = 1'b0;
        total++; if (protocol_err_o !== 1'b1) begin bad++;
            $display("FAIL rm_late_perr got=%b exp=1", protocol_err_o); end
        m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1;
        @(negedge clk);
        total++; if ({m1_gnt_o, m0_gnt_o} !== 2'b01) begin bad++;
            $display("FAIL rm_prio got=%b exp=01", {m1_gnt_o, m0_gnt_o}); end
        exp_q.push_back(1'b0);
        next_cycle();
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if ({m1_rvalid_o, m0_rvalid_o} !== (e ? 2'b10 : 2'b01)) begin bad++;
            $display("FAIL rm_resp got=%b exp_master=%0d", {m1_rvalid_o, m0_rvalid_o}, e); end
        next_cycle();
        s_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_push_pop();
        test_stray();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog expired total=%0d", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, max outstanding granted-but-unanswered transactions (power of 2, 1..8).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have ports m0_req_i, m0_we_i, input, 1 each, master 0 (core instruction side) request and write-enable.
REQ-005 The block SHALL have ports m0_addr_i, m0_wdata_i, input, 32 each; m0_be_i, input, 4; master 0 address, write data and byte enables.
REQ-006 The block SHALL have ports m0_gnt_o, m0_rvalid_o, m0_err_o, output, 1 each; m0_rdata_o, output, 32; master 0 response.
REQ-007 The block SHALL have ports m1_* identical to m0_* (REQ-004..006) for master 1 (core data side).
REQ-008 The block SHALL have ports s_req_o, s_we_o, output, 1; s_addr_o, s_wdata_o, output, 32; s_be_o, output, 4; shared slave request.
REQ-009 The block SHALL have ports s_gnt_i, s_rvalid_i, s_err_i, input, 1; s_rdata_i, input, 32; shared slave response.
REQ-010 The block SHALL have port protocol_err_o, output, 1, sticky flag for a response with no outstanding transaction.

Function
REQ-011 Protocol: req held until gnt; one transaction transfers on the cycle where s_req_o && s_gnt_i; response is one s_rvalid_i cycle, in order, at least 1 cycle after gnt.
REQ-012 Selection: when the owner FIFO is not full, one master is selected; s_req_o/s_addr_o/s_we_o/s_be_o/s_wdata_o SHALL combinationally mirror the selected master.
REQ-013 Round-robin: pointer prio, reset value 0; if both request, master prio wins; after any grant to master N, prio SHALL become 1-N at the next edge.
REQ-014 Single requester SHALL be selected regardless of prio.
REQ-015 Lock: if s_req_o is asserted and s_gnt_i is low, selection SHALL stay on that master on following cycles until granted, even if the other master has priority.
REQ-016 The granted master SHALL see mN_gnt_o = s_gnt_i && selected; the other master's gnt SHALL be 0.
REQ-017 Owner FIFO: DEPTH entries of 1-bit master ID; push selected ID on s_req_o && s_gnt_i; pop on s_rvalid_i when non-empty.
REQ-018 Full: when count == DEPTH, s_req_o SHALL be 0 and no gnt reaches any master, even if a pop occurs in the same cycle.
REQ-019 Simultaneous push and pop when not full SHALL leave count unchanged and preserve order.
REQ-020 Response routing: on s_rvalid_i with FIFO non-empty, mH_rvalid_o=1 and mH_err_o=s_err_i for head ID H; the other master gets rvalid=0 and err=0, combinationally in the same cycle.
REQ-021 m0_rdata_o and m1_rdata_o SHALL both equal s_rdata_i at all times; qualification is by rvalid only.
REQ-022 Stray response: s_rvalid_i with FIFO empty SHALL be dropped, with no master rvalid, and SHALL set protocol_err_o, held until reset.
REQ-023 Latency: zero added cycles on request and response paths; no registered data.

Reset
REQ-024 While rst=1: FIFO empty (count 0, pointers 0), prio=0, lock cleared, protocol_err_o=0.
REQ-025 Outputs during reset SHALL follow REQ-012..021 with empty state: s_req_o mirrors a requester, and every mN_rvalid_o=0.
REQ-026 Reset asserted mid-transaction SHALL discard all outstanding IDs; responses arriving after reset SHALL be treated as stray per REQ-022.

Verification
REQ-027 Both masters request at 0x80 and 0x1000, s_gnt_i=1 always -> m0 granted in cycle 0 and m1 in cycle 1, alternating while both request.
REQ-028 Slave holds s_gnt_i=0 for 3 cycles with m0 selected, and m1 requests with prio=1 -> s_addr_o stays m0's address until gnt; m1 granted next.
REQ-029 DEPTH=2, two grants (m0, m1) with no rvalid -> s_req_o=0 on the third request; then rvalid with s_rdata_i=0x00000513 -> m0_rvalid_o=1 and m0_rdata_o=0x00000513; next rvalid goes to m1.
REQ-030 Push and pop in the same cycle at count 1 -> count stays 1, and the next rvalid goes to the correct master.
REQ-031 s_rvalid_i=1 with the FIFO empty -> no mN_rvalid_o, and protocol_err_o=1 until rst is asserted.
REQ-032 rst pulsed with 2 outstanding transactions -> FIFO empty and prio=0; a late s_rvalid_i sets protocol_err_o.
